mem_access_stage: RTL and testbench



---
 rtl/mem_pkg.sv | 19 +
 rtl/mem_access_stage_if.sv | 21 ++
 rtl/mem_load_align.sv | 32 +++
 rtl/mem_access_stage.sv | 152 +++++++++++++++
 tb/tb_mem_access_stage.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared constants for the MEM-stage data-memory access path.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } mem_state_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory bus: req/gnt request phase, rvalid/rdata response phase.
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_load_align.sv
// Selects the addressed byte/half of a read word and extends it per funct3.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by sign/zero extension; LW and anything else pass the word.
  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'b0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'b0, half_sel};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage core: drives the data bus, aligns load data, stalls while an
// access is outstanding and gates the writeback enable.
//
// state | meaning
// IDLE  | no access pending; a legal op raises req combinationally
// REQ   | req held with stable attributes until gnt
// WAIT  | load granted, waiting for rvalid or timeout
// DONE  | result/bus_err presented, pipeline advances on this edge
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int TO_W           = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_MEM_in,
  input  logic [31:0] alu_MEM_in,
  input  logic [31:0] rs2_MEM_in,
  input  logic [2:0]  funct3_MEM_in,
  input  logic        MemRead_MEM_in,
  input  logic        MemWrite_MEM_in,
  input  logic        RegWrite_MEM_in,
  input  logic        MemtoReg_MEM_in,
  input  logic [4:0]  rd_MEM_in,
  mem_access_stage_if.master dmem,
  output logic [31:0] mem_data_MEM_out,
  output logic [31:0] alu_MEM_out,
  output logic        RegWrite_MEM_out,
  output logic        MemtoReg_MEM_out,
  output logic [4:0]  rd_MEM_out,
  output logic        stall_MEM_out,
  output logic        misalign_MEM_out,
  output logic        bus_err_MEM_out
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  mem_state_t      state;
  logic [TO_W-1:0] to_cnt;
  logic [31:0]     ld_buf;
  logic            err_flag;
  logic [31:0]     ld_data;

  logic        mem_op, is_store, is_load, legal, start, stall_c;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;

  mem_load_align u_align (
    .rdata     (dmem.dmem_rdata),
    .addr_lo   (alu_MEM_in[1:0]),
    .funct3    (funct3_MEM_in),
    .load_data (ld_data)
  );

  // Access classification and size/alignment legality.
  always_comb begin
    mem_op   = valid_MEM_in & (MemRead_MEM_in | MemWrite_MEM_in);
    is_store = MemWrite_MEM_in;
    is_load  = MemRead_MEM_in & ~MemWrite_MEM_in;
    case (funct3_MEM_in)
      F3_B, F3_BU: legal = 1'b1;
      F3_H, F3_HU: legal = ~alu_MEM_in[0];
      F3_W:        legal = (alu_MEM_in[1:0] == 2'b00);
      default:     legal = 1'b0;
    endcase
    start = mem_op & legal;
  end

  // Store lane replication and byte enables.
  always_comb begin
    case (funct3_MEM_in)
      F3_B, F3_BU: begin
        st_wdata = {4{rs2_MEM_in[7:0]}};
        st_be    = 4'b0001 << alu_MEM_in[1:0];
      end
      F3_H, F3_HU: begin
        st_wdata = {2{rs2_MEM_in[15:0]}};
        st_be    = alu_MEM_in[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = rs2_MEM_in;
        st_be    = 4'b1111;
      end
    endcase
  end

  // Bus drive and pipeline-facing outputs; reset forces req/stall/RegWrite low.
  always_comb begin
    case (state)
      ST_IDLE: stall_c = start & ~(is_store & dmem.dmem_gnt);
      ST_REQ:  stall_c = 1'b1;
      ST_WAIT: stall_c = 1'b1;
      default: stall_c = 1'b0;
    endcase
    dmem.dmem_req    = rst_n & (((state == ST_IDLE) & start) | (state == ST_REQ));
    dmem.dmem_we     = is_store;
    dmem.dmem_addr   = {alu_MEM_in[31:2], 2'b00};
    dmem.dmem_be     = is_store ? st_be : 4'b1111;
    dmem.dmem_wdata  = st_wdata;
    stall_MEM_out    = rst_n & stall_c;
    misalign_MEM_out = (state == ST_IDLE) & mem_op & ~legal;
    bus_err_MEM_out  = (state == ST_DONE) & err_flag;
    mem_data_MEM_out = ((state == ST_DONE) & is_load) ? ld_buf : 32'b0;
    RegWrite_MEM_out = rst_n & RegWrite_MEM_in & ~stall_c & ~misalign_MEM_out & ~bus_err_MEM_out;
    alu_MEM_out      = alu_MEM_in;
    MemtoReg_MEM_out = MemtoReg_MEM_in;
    rd_MEM_out       = rd_MEM_in;
  end

  // Access sequencing, load capture and read timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      to_cnt   <= '0;
      ld_buf   <= 32'b0;
      err_flag <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (dmem.dmem_gnt) state <= is_store ? ST_IDLE : ST_WAIT;
            else               state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (dmem.dmem_gnt) state <= is_store ? ST_DONE : ST_WAIT;
        end
        ST_WAIT: begin
          // rvalid is checked first so a response on the timeout cycle still wins
          if (dmem.dmem_rvalid) begin
            ld_buf <= ld_data;
            to_cnt <= '0;
            state  <= ST_DONE;
          end else if (to_cnt == TO_LIMIT) begin
            ld_buf   <= 32'b0;
            err_flag <= 1'b1;
            to_cnt   <= '0;
            state    <= ST_DONE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: begin
          err_flag <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a per-instruction timing/value model
// drives expectations that one negedge process compares every cycle.
module tb_mem_access_stage;

  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_MEM_in, MemRead_MEM_in, MemWrite_MEM_in, RegWrite_MEM_in, MemtoReg_MEM_in;
  logic [31:0] alu_MEM_in, rs2_MEM_in;
  logic [2:0]  funct3_MEM_in;
  logic [4:0]  rd_MEM_in;
  logic [31:0] mem_data_MEM_out, alu_MEM_out;
  logic        RegWrite_MEM_out, MemtoReg_MEM_out, stall_MEM_out, misalign_MEM_out, bus_err_MEM_out;
  logic [4:0]  rd_MEM_out;

  mem_access_stage_if dmem();

  mem_access_stage #(.TIMEOUT_CYCLES(TMO), .TO_W(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .valid_MEM_in     (valid_MEM_in),
    .alu_MEM_in       (alu_MEM_in),
    .rs2_MEM_in       (rs2_MEM_in),
    .funct3_MEM_in    (funct3_MEM_in),
    .MemRead_MEM_in   (MemRead_MEM_in),
    .MemWrite_MEM_in  (MemWrite_MEM_in),
    .RegWrite_MEM_in  (RegWrite_MEM_in),
    .MemtoReg_MEM_in  (MemtoReg_MEM_in),
    .rd_MEM_in        (rd_MEM_in),
    .dmem             (dmem),
    .mem_data_MEM_out (mem_data_MEM_out),
    .alu_MEM_out      (alu_MEM_out),
    .RegWrite_MEM_out (RegWrite_MEM_out),
    .MemtoReg_MEM_out (MemtoReg_MEM_out),
    .rd_MEM_out       (rd_MEM_out),
    .stall_MEM_out    (stall_MEM_out),
    .misalign_MEM_out (misalign_MEM_out),
    .bus_err_MEM_out  (bus_err_MEM_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory responder: gnt after gnt_delay requesting cycles, rvalid rv_delay
  // cycles after the grant (rv_delay == 0 means the read never returns).
  int          gnt_delay = 0;
  int          rv_delay  = 0;
  int          req_seen  = 0;
  int          rv_left   = 0;
  logic [31:0] rdata_cfg = 32'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_seen <= 0;
      rv_left  <= 0;
    end else begin
      if (dmem.dmem_req && !dmem.dmem_gnt) req_seen <= req_seen + 1;
      else                                 req_seen <= 0;
      if (dmem.dmem_req && dmem.dmem_gnt && !dmem.dmem_we) rv_left <= rv_delay;
      else if (rv_left > 0)                                rv_left <= rv_left - 1;
    end
  end

  assign dmem.dmem_gnt    = dmem.dmem_req && (req_seen == gnt_delay);
  assign dmem.dmem_rvalid = (rv_left == 1);
  assign dmem.dmem_rdata  = rdata_cfg;

  // Expected outputs for the current cycle, set by run_op.
  logic        chk_en = 1'b0;
  logic        e_req, e_stall, e_rw, e_mis, e_err, e_we;
  logic [31:0] e_mdata, e_addr, e_wdata;
  logic [3:0]  e_be;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall",    32'(stall_MEM_out),    32'(e_stall));
      chk("req",      32'(dmem.dmem_req),    32'(e_req));
      chk("regwrite", 32'(RegWrite_MEM_out), 32'(e_rw));
      chk("misalign", 32'(misalign_MEM_out), 32'(e_mis));
      chk("bus_err",  32'(bus_err_MEM_out),  32'(e_err));
      chk("mem_data", mem_data_MEM_out,      e_mdata);
      chk("alu_pass", alu_MEM_out,           alu_MEM_in);
      chk("rd_pass",  32'(rd_MEM_out),       32'(rd_MEM_in));
      chk("m2r_pass", 32'(MemtoReg_MEM_out), 32'(MemtoReg_MEM_in));
      if (e_req) begin
        chk("addr",  dmem.dmem_addr,     e_addr);
        chk("be",    32'(dmem.dmem_be),  32'(e_be));
        chk("we",    32'(dmem.dmem_we),  32'(e_we));
        chk("wdata", dmem.dmem_wdata,    e_wdata);
      end
    end
  end

  // One instruction held in MEM until it leaves; entered and left at posedge+1.
  // Timing model: request cycles 0..g, then r WAIT cycles for a load (TMO+1
  // if the read times out), then one DONE cycle; a store granted at once never stalls.
  task automatic run_op(input logic ld_i, input logic st_i, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] rdat,
                        input int g, input int r, input logic rw,
                        output logic [31:0] got_data, output int got_stalls);
    int          sz, lane, S, wait_n;
    logic        mem, legal, ld, st, tmo;
    logic [31:0] sh, ext;
    mem  = ld_i | st_i;
    st   = st_i;
    ld   = ld_i & ~st_i;
    lane = int'(addr[1:0]);
    case (f3)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2:       sz = 4;
      default:    sz = 0;
    endcase
    legal  = (sz != 0) && (lane % sz == 0);
    tmo    = ld && (r == 0 || r > TMO + 1);
    wait_n = tmo ? TMO + 1 : r;
    if (!mem || !legal) S = 0;
    else if (st)        S = (g == 0) ? 0 : g + 1;
    else                S = g + 1 + wait_n;
    sh = rdat >> (8 * lane);
    if (sz == 1) begin
      ext = sh & 32'hFF;
      if (f3 == 3'd0 && ext >= 32'd128) ext = ext - 32'd256;
    end else if (sz == 2) begin
      ext = sh & 32'hFFFF;
      if (f3 == 3'd1 && ext >= 32'd32768) ext = ext - 32'd65536;
    end else begin
      ext = rdat;
    end
    valid_MEM_in    = 1'b1;
    MemRead_MEM_in  = ld_i;
    MemWrite_MEM_in = st_i;
    funct3_MEM_in   = f3;
    alu_MEM_in      = addr;
    rs2_MEM_in      = rs2;
    RegWrite_MEM_in = rw;
    MemtoReg_MEM_in = ld_i;
    rd_MEM_in       = addr[6:2];
    gnt_delay       = g;
    rv_delay        = tmo ? 0 : r;
    rdata_cfg       = rdat;
    got_stalls      = 0;
    got_data        = 32'b0;
    for (int i = 0; i <= S; i++) begin
      e_req   = mem && legal && (i <= g);
      e_stall = (i < S);
      e_we    = st;
      e_addr  = addr & 32'hFFFF_FFFC;
      e_be    = st ? 4'(((1 << sz) - 1) << lane) : 4'hF;
      e_wdata = (sz == 1) ? 32'(rs2[7:0]) * 32'h0101_0101 :
                (sz == 2) ? 32'(rs2[15:0]) * 32'h0001_0001 : rs2;
      e_mdata = (ld && legal && i == S && !tmo) ? ext : 32'b0;
      e_err   = tmo && legal && (i == S);
      e_mis   = mem && !legal;
      e_rw    = rw && (i == S) && !e_mis && !e_err;
      chk_en  = 1'b1;
      @(negedge clk);
      if (stall_MEM_out) got_stalls++;
      if (i == S) got_data = mem_data_MEM_out;
      @(posedge clk);
      #1;
    end
  endtask

  logic [31:0] d;
  int          st_n;

  initial begin
    valid_MEM_in = 1'b1; MemRead_MEM_in = 1'b1; MemWrite_MEM_in = 1'b0;
    RegWrite_MEM_in = 1'b1; MemtoReg_MEM_in = 1'b1; funct3_MEM_in = 3'd2;
    alu_MEM_in = 32'h40; rs2_MEM_in = 32'b0; rd_MEM_in = 5'd1;
    #2;
    chk("rst_req",      32'(dmem.dmem_req),    32'd0);
    chk("rst_stall",    32'(stall_MEM_out),    32'd0);
    chk("rst_regwrite", 32'(RegWrite_MEM_out), 32'd0);
    chk("rst_mem_data", mem_data_MEM_out,      32'd0);
    valid_MEM_in = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // SB, same-cycle grant
    run_op(1'b0, 1'b1, 3'd0, 32'h102, 32'h0000_00AB, 32'h0, 0, 0, 1'b0, d, st_n);
    chk("sb_stalls", 32'(st_n), 32'd0);
    chk("sb_be_lit", 32'(dmem.dmem_be), 32'h4);
    chk("sb_wdata_lit", dmem.dmem_wdata, 32'hABAB_ABAB);
    // LB, zero-wait memory
    run_op(1'b1, 1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_1234, 0, 1, 1'b1, d, st_n);
    chk("lb_stalls", 32'(st_n), 32'd2);
    chk("lb_data", d, 32'hFFFF_FF80);
    // LHU, grant on 3rd request cycle, rvalid 2 after grant
    run_op(1'b1, 1'b0, 3'd5, 32'h102, 32'h0, 32'h80FF_1234, 2, 2, 1'b1, d, st_n);
    chk("lhu_stalls", 32'(st_n), 32'd5);
    chk("lhu_data", d, 32'h0000_80FF);
    // misaligned LW
    run_op(1'b1, 1'b0, 3'd2, 32'h101, 32'h0, 32'h0, 0, 1, 1'b1, d, st_n);
    chk("lw_mis_stalls", 32'(st_n), 32'd0);
    // SH upper half, grant one cycle late
    run_op(1'b0, 1'b1, 3'd1, 32'h106, 32'h1234_BEEF, 32'h0, 1, 0, 1'b0, d, st_n);
    chk("sh_stalls", 32'(st_n), 32'd2);
    // LH sign-extend, slow read
    run_op(1'b1, 1'b0, 3'd1, 32'h100, 32'h0, 32'h0000_8001, 0, 3, 1'b1, d, st_n);
    chk("lh_data", d, 32'hFFFF_8001);
    // non-memory instruction
    run_op(1'b0, 1'b0, 3'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, 0, 0, 1'b1, d, st_n);
    chk("alu_stalls", 32'(st_n), 32'd0);
    // illegal funct3 load
    run_op(1'b1, 1'b0, 3'd3, 32'h100, 32'h0, 32'h0, 0, 1, 1'b1, d, st_n);
    // LBU byte lane 1
    run_op(1'b1, 1'b0, 3'd4, 32'h101, 32'h0, 32'h1234_A5C3, 1, 1, 1'b1, d, st_n);
    chk("lbu_data", d, 32'h0000_00A5);
    // LW that never returns: timeout
    run_op(1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 32'h5555_5555, 0, 0, 1'b1, d, st_n);
    chk("tmo_stalls", 32'(st_n), 32'd257);
    chk("tmo_data", d, 32'h0);
    // LW whose data arrives on the timeout cycle
    run_op(1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 32'hCAFE_F00D, 0, 256, 1'b1, d, st_n);
    chk("edge_stalls", 32'(st_n), 32'd257);
    chk("edge_data", d, 32'hCAFE_F00D);

    // reset asserted while a load sits in WAIT
    chk_en = 1'b0;
    valid_MEM_in = 1'b1; MemRead_MEM_in = 1'b1; MemWrite_MEM_in = 1'b0;
    funct3_MEM_in = 3'd2; alu_MEM_in = 32'h100; RegWrite_MEM_in = 1'b1;
    gnt_delay = 0; rv_delay = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("wait_stall", 32'(stall_MEM_out), 32'd1);
    chk("wait_req",   32'(dmem.dmem_req), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req",      32'(dmem.dmem_req),    32'd0);
    chk("mid_rst_stall",    32'(stall_MEM_out),    32'd0);
    chk("mid_rst_regwrite", 32'(RegWrite_MEM_out), 32'd0);
    @(posedge clk); #1;
    valid_MEM_in = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(1'b0, 1'b1, 3'd2, 32'h200, 32'h1122_3344, 32'h0, 0, 0, 1'b0, d, st_n);
    chk("sw_stalls", 32'(st_n), 32'd0);
    chk("sw_be_lit", 32'(dmem.dmem_be), 32'hF);
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
